frame_tick_div: RTL and testbench

- Multi-channel frame-synchronous divider for the VGA game path.
- Detects entry of the scan into a trigger row and emits a one-cycle frame tick.
- Derives NCH independent programmable-rate tick pulses and toggle levels from that tick, used for sprite animation, obstacle motion and score pacing.
- Adds per-channel ratios, pause and a free-running frame counter on top of the single fixed toggle the design uses today.

---
 rtl/frame_tick_pkg.sv | 20 ++
 rtl/frame_tick_div_if.sv | 38 +++
 rtl/frame_div_chan.sv | 60 ++++++
 rtl/frame_tick_div.sv | 74 +++++++
 tb/tb_frame_tick_div.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_pkg
//  Description : Shared defaults and types for the frame-synchronous tick
//                divider (channel count, field widths, trigger row).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package frame_tick_pkg;

  localparam int unsigned NCH_DEF      = 4;
  localparam int unsigned DIV_W_DEF    = 4;
  localparam int unsigned ROW_W_DEF    = 9;
  localparam int unsigned TRIG_ROW_DEF = 511;
  localparam int unsigned CNT_W_DEF    = 16;

  typedef logic [DIV_W_DEF-1:0] ratio_t;

endpackage
`default_nettype wire

// File: rtl/frame_tick_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_div_if
//  Description : Bundle of the divider's scan input, controls and tick
//                outputs. master = VGA/game side, slave = divider.
//  Signals     : row_addr, pause, div_ratio (to divider)
//                frame_tick, frame_cnt, ch_tick, ch_level (from divider)
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_tick_div_if
  import frame_tick_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic [ROW_W-1:0]     row_addr;
  logic                 pause;
  logic [NCH*DIV_W-1:0] div_ratio;
  logic                 frame_tick;
  logic [CNT_W-1:0]     frame_cnt;
  logic [NCH-1:0]       ch_tick;
  logic [NCH-1:0]       ch_level;

  modport master (
    output row_addr, pause, div_ratio,
    input  frame_tick, frame_cnt, ch_tick, ch_level
  );

  modport slave (
    input  row_addr, pause, div_ratio,
    output frame_tick, frame_cnt, ch_tick, ch_level
  );

endinterface
`default_nettype wire

// File: rtl/frame_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : frame_div_chan
//  Description : One divider channel. Counts frame events and wraps after
//                'ratio' of them, emitting a one-cycle tick and toggling a
//                level on each wrap. ratio==0 parks the channel.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                frame_evt       combinational frame event (one cycle)
//                pause           freeze counter / suppress tick
//                ratio           wrap ratio, sampled on every event
//                tick, level     registered outputs
//  Revision    : 1.0  initial release
// ============================================================================
module frame_div_chan #(
  parameter int unsigned DIV_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             frame_evt,
  input  wire logic             pause,
  input  wire logic [DIV_W-1:0] ratio,
  output logic                  tick,
  output logic                  level
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_level;
  logic             w_last;

  // Only meaningful when ratio != 0, so the subtraction never underflows in
  // a case that matters. Using >= lets a lowered ratio wrap immediately.
  assign w_last = (r_cnt >= (ratio - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (ratio == '0) begin
        r_cnt <= '0;
      end else if (frame_evt && !pause) begin
        if (w_last) begin
          r_cnt   <= '0;
          r_tick  <= 1'b1;
          r_level <= ~r_level;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign tick  = r_tick;
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/frame_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_div
//  Description : Frame-synchronous multi-channel tick divider. Detects entry
//                of the scan into TRIG_ROW, emits frame_tick one cycle later,
//                counts frames and drives NCH programmable divider channels.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                bus        frame_tick_div_if slave (row_addr, pause,
//                           div_ratio in; frame_tick, frame_cnt, ch_tick,
//                           ch_level out)
//  Revision    : 1.0  initial release
// ============================================================================
module frame_tick_div
  import frame_tick_pkg::*;
#(
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned ROW_W    = ROW_W_DEF,
  parameter int unsigned TRIG_ROW = TRIG_ROW_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input wire logic         clk,
  input wire logic         rst,
  frame_tick_div_if.slave  bus
);

  logic             w_hit;
  logic             w_evt;
  logic             r_hit_prev;
  logic             r_frame_tick;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [NCH-1:0]   w_ch_tick;
  logic [NCH-1:0]   w_ch_level;

  assign w_hit = (bus.row_addr == ROW_W'(TRIG_ROW));
  assign w_evt = w_hit && !r_hit_prev;

  // hit_prev resets high so a row already parked on TRIG_ROW at reset
  // release does not count as an entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_prev   <= 1'b1;
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_hit_prev   <= w_hit;
      r_frame_tick <= w_evt;
      if (w_evt) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    frame_div_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .frame_evt (w_evt),
      .pause     (bus.pause),
      .ratio     (bus.div_ratio[gi*DIV_W +: DIV_W]),
      .tick      (w_ch_tick[gi]),
      .level     (w_ch_level[gi])
    );
  end

  assign bus.frame_tick = r_frame_tick;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.ch_tick    = w_ch_tick;
  assign bus.ch_level   = w_ch_level;

endmodule
`default_nettype wire

// File: tb/tb_frame_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_tick_div
//  Description : Self-checking bench for frame_tick_div. A frame-level
//                reference model (entry detection, per-channel frame counts
//                modulo ratio) predicts every output after every clock.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_tick_div;
  import frame_tick_pkg::*;

  localparam int unsigned C_NCH   = 4;
  localparam int unsigned C_DIV_W = 4;
  localparam int unsigned C_ROW_W = 9;
  localparam int unsigned C_CNT_W = 16;
  localparam int unsigned C_TRIG  = 511;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  frame_tick_div_if #(
    .NCH(C_NCH), .DIV_W(C_DIV_W), .ROW_W(C_ROW_W), .CNT_W(C_CNT_W)
  ) bus ();

  frame_tick_div #(
    .NCH(C_NCH), .DIV_W(C_DIV_W), .ROW_W(C_ROW_W),
    .TRIG_ROW(C_TRIG), .CNT_W(C_CNT_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: frames counted per channel since its last wrap.
  bit          m_on_row;
  bit          m_ft;
  int unsigned m_fcnt;
  int unsigned m_frames[C_NCH];
  bit          m_lvl[C_NCH];
  bit          m_tick[C_NCH];
  int          ft_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned ratio_of(int ch);
    ratio_t r;
    r = ratio_t'(bus.div_ratio >> (C_DIV_W * ch));
    return int'(r);
  endfunction

  // Advance the model by one clock using the inputs presented right now.
  task automatic model_clock();
    bit entered;
    if (rst) begin
      m_on_row = 1'b1;
      m_ft     = 1'b0;
      m_fcnt   = 0;
      for (int i = 0; i < C_NCH; i++) begin
        m_frames[i] = 0; m_lvl[i] = 1'b0; m_tick[i] = 1'b0;
      end
    end else begin
      entered  = (bus.row_addr == C_ROW_W'(C_TRIG)) && !m_on_row;
      m_on_row = (bus.row_addr == C_ROW_W'(C_TRIG));
      m_ft     = entered;
      if (entered) m_fcnt = (m_fcnt + 1) % (1 << C_CNT_W);
      for (int i = 0; i < C_NCH; i++) begin
        m_tick[i] = 1'b0;
        if (ratio_of(i) == 0) begin
          m_frames[i] = 0;
        end else if (entered && !bus.pause) begin
          if (m_frames[i] + 1 >= ratio_of(i)) begin
            m_frames[i] = 0;
            m_tick[i]   = 1'b1;
            m_lvl[i]    = !m_lvl[i];
          end else begin
            m_frames[i] = m_frames[i] + 1;
          end
        end
      end
    end
  endtask

  function automatic logic [C_NCH-1:0] pack(input bit v[C_NCH]);
    logic [C_NCH-1:0] p;
    for (int i = 0; i < C_NCH; i++) p[i] = v[i];
    return p;
  endfunction

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    if (bus.frame_tick === 1'b1) ft_pulses++;
    check("frame_tick", 32'(bus.frame_tick), 32'(m_ft));
    check("frame_cnt",  32'(bus.frame_cnt),  m_fcnt);
    check("ch_tick",    32'(bus.ch_tick),    32'(pack(m_tick)));
    check("ch_level",   32'(bus.ch_level),   32'(pack(m_lvl)));
  endtask

  task automatic frame_event();
    bus.row_addr = '0;
    step();
    bus.row_addr = C_ROW_W'(C_TRIG);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int unsigned base_cnt;
  logic [C_NCH-1:0] held_lvl;

  initial begin
    bus.row_addr  = '0;
    bus.pause     = 1'b0;
    bus.div_ratio = {4'd0, 4'd3, 4'd2, 4'd1};
    ft_pulses     = 0;

    // Reset state
    do_reset();
    check("reset_cnt", 32'(bus.frame_cnt), 32'd0);
    check("reset_lvl", 32'(bus.ch_level), 32'd0);

    // Six full row sweeps with ratios {1,2,3,0}
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < 512; r++) begin
        bus.row_addr = C_ROW_W'(r);
        step();
        if (r == 511) check("sweep_tick", 32'(bus.frame_tick), 32'd1);
      end
    end
    check("sweep_cnt6", 32'(bus.frame_cnt), 32'd6);
    check("sweep_lvl",  32'(bus.ch_level), 32'b0010);

    // Row held on trigger: 0, 511 x10, 0, 511 -> two pulses
    ft_pulses = 0;
    bus.row_addr = '0;
    step();
    bus.row_addr = C_ROW_W'(C_TRIG);
    for (int k = 0; k < 10; k++) step();
    bus.row_addr = '0;
    step();
    bus.row_addr = C_ROW_W'(C_TRIG);
    step();
    step();
    check("hold_pulses", 32'(ft_pulses), 32'd2);

    // Reset released with the row already on the trigger row
    bus.row_addr = C_ROW_W'(C_TRIG);
    do_reset();
    for (int k = 0; k < 5; k++) step();
    check("parked_cnt", 32'(bus.frame_cnt), 32'd0);
    frame_event();
    check("parked_first", 32'(bus.frame_cnt), 32'd1);

    // Ratio lowered below the running count on ch1
    bus.div_ratio = {4'd0, 4'd0, 4'd8, 4'd0};
    do_reset();
    for (int k = 0; k < 5; k++) frame_event();
    bus.div_ratio = {4'd0, 4'd0, 4'd3, 4'd0};
    frame_event();
    check("lower_ratio_tick", 32'(bus.ch_tick[1]), 32'd1);
    frame_event();
    frame_event();
    check("lower_ratio_mid", 32'(bus.ch_tick[1]), 32'd0);
    frame_event();
    check("lower_ratio_wrap", 32'(bus.ch_tick[1]), 32'd1);

    // Pause across three frames with ratio 2 everywhere
    bus.div_ratio = {4'd2, 4'd2, 4'd2, 4'd2};
    do_reset();
    frame_event();
    base_cnt = 32'(bus.frame_cnt);
    held_lvl = bus.ch_level;
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) frame_event();
    check("pause_cnt", 32'(bus.frame_cnt), base_cnt + 3);
    check("pause_lvl", 32'(bus.ch_level), 32'(held_lvl));
    bus.pause = 1'b0;
    frame_event();
    check("resume_tick", 32'(bus.ch_tick), 32'hF);

    // Reset right after a wrap on ch0 (ratio 1) and ch1 (ratio 2)
    bus.div_ratio = {4'd0, 4'd0, 4'd2, 4'd1};
    do_reset();
    frame_event();
    frame_event();
    check("wrap_before_rst", 32'(bus.ch_tick), 32'b0011);
    do_reset();
    check("rst_lvl", 32'(bus.ch_level), 32'd0);
    check("rst_cnt", 32'(bus.frame_cnt), 32'd0);
    frame_event();
    check("post_rst_tick", 32'(bus.ch_tick), 32'b0001);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) < 4) bus.row_addr = C_ROW_W'(C_TRIG);
      else                          bus.row_addr = C_ROW_W'($urandom_range(0, 511));
      bus.pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) bus.div_ratio = 16'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
